// File: rtl/seq_detect_sched.sv
// seq_detect_sched: one "1011" overlapping pattern matcher shared by NCH
// serial bit streams.
//
// Each channel keeps its own 3-bit match context. A round-robin arbiter
// grants one valid channel per cycle. Only the granted channel's context
// advances.
//
// A completed pattern is reported one cycle after the accepting edge, as a
// match_valid pulse tagged with match_chan.
//
// A clear request resets one channel's context to S0. It also removes that
// channel from arbitration in the same cycle, so a bit offered on the
// channel being cleared is never consumed.
//
// Optional build macro SEQ_DETECT_MATCH_CNT_EN adds a saturating 16-bit
// match counter on output match_total. The counter is reset only by resetn.

// Per-channel match context: a 1011 overlapping detector advanced one bit per grant.
module seq_detect_ctx (
  input  logic       clk,
  input  logic       resetn,
  input  logic       adv,
  input  logic       b,
  input  logic       clr,
  output logic [2:0] st,
  output logic       hit
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } ctx_e;

  ctx_e st_q;
  ctx_e st_nxt;

  // Next-state table; unused encodings fall back to the S0 row.
  always_comb begin
    st_nxt = S0;
    case (st_q)
      S1:      st_nxt = b ? S1 : S2;
      S2:      st_nxt = b ? S3 : S0;
      S3:      st_nxt = b ? S4 : S2;
      S4:      st_nxt = b ? S1 : S2;
      default: st_nxt = b ? S1 : S0;
    endcase
  end

  // Context register. A clear wins over an advance, although the arbiter
  // never grants a channel that is being cleared.
  always_ff @(posedge clk) begin
    if (!resetn)  st_q <= S0;
    else if (clr) st_q <= S0;
    else if (adv) st_q <= st_nxt;
  end

  assign st  = st_q;
  assign hit = adv && (st_q == S3) && b;

endmodule

// Top level: round-robin grant, per-lane contexts, registered match report.
module seq_detect_sched #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [NCH-1:0] bit_valid,
  input  logic [NCH-1:0] bit_data,
  output logic [NCH-1:0] bit_ready,
  input  logic           clr_valid,
  input  logic [CHW-1:0] clr_chan,
`ifdef SEQ_DETECT_MATCH_CNT_EN
  output logic [15:0]    match_total,
`endif
  output logic           match_valid,
  output logic [CHW-1:0] match_chan
);

  localparam int NSLOT = 2**CHW;

  logic [CHW-1:0]         rr;
  logic [CHW-1:0]         gnt_idx;
  logic                   acc;
  logic [NCH-1:0]         clr_mask;
  logic [NSLOT-1:0]       elig;
  logic [NCH-1:0]         hit;
  logic [NCH-1:0][2:0]    ctx;

  // Decode the clear request. Channel ids of NCH and above select nothing.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NCH; i++)
      clr_mask[i] = clr_valid && (clr_chan == CHW'(i));
  end

  // Eligible channels, padded to 2**CHW so a CHW-bit index is always in range.
  always_comb begin
    elig = '0;
    elig[NCH-1:0] = bit_valid & ~clr_mask;
  end

  // Scan from rr, wrapping modulo NCH, and take the first eligible channel.
  // The scan looks only at bit_valid and the clear request, never at bit_data.
  always_comb begin
    logic [CHW:0] s;
    acc     = 1'b0;
    gnt_idx = rr;
    for (int i = 0; i < NCH; i++) begin
      s = {1'b0, rr} + (CHW+1)'(i);
      if (s >= (CHW+1)'(NCH)) s = s - (CHW+1)'(NCH);
      if (!acc && elig[s[CHW-1:0]]) begin
        acc     = 1'b1;
        gnt_idx = s[CHW-1:0];
      end
    end
  end

  // One-hot grant vector built from the winning index.
  always_comb begin
    bit_ready = '0;
    for (int i = 0; i < NCH; i++)
      bit_ready[i] = acc && (gnt_idx == CHW'(i));
  end

  // Round-robin pointer moves to the channel after the one just served.
  always_ff @(posedge clk) begin
    if (!resetn)
      rr <= '0;
    else if (acc)
      rr <= ({1'b0, gnt_idx} + 1'b1 == (CHW+1)'(NCH)) ? '0 : gnt_idx + 1'b1;
  end

  // One context instance per channel. A lane advances only when it is granted.
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    seq_detect_ctx u_ctx (
      .clk    (clk),
      .resetn (resetn),
      .adv    (bit_ready[i]),
      .b      (bit_data[i]),
      .clr    (clr_mask[i]),
      .st     (ctx[i]),
      .hit    (hit[i])
    );
  end

  // Registered detection pulse.
  // match_chan is updated only when a match fires; otherwise it holds.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      match_valid <= 1'b0;
      match_chan  <= '0;
    end else begin
      match_valid <= |hit;
      if (|hit) match_chan <= gnt_idx;
    end
  end

`ifdef SEQ_DETECT_MATCH_CNT_EN
  // Saturating count of reported matches. Unaffected by clr_valid.
  always_ff @(posedge clk) begin
    if (!resetn)
      match_total <= '0;
    else if (|hit && match_total != 16'hFFFF)
      match_total <= match_total + 16'd1;
  end
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched with NCH=4 and CHW=2.
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit later.
module tb_seq_detect_sched;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] bit_valid, bit_data, bit_ready;
  logic       clr_valid;
  logic [1:0] clr_chan;
  logic       match_valid;
  logic [1:0] match_chan;
`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [15:0] match_total;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  logic       exp_mv = 1'b0;
  logic [1:0] exp_mc = 2'd0;

  always #5 clk = ~clk;

  seq_detect_sched #(.NCH(4), .CHW(2)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .bit_ready   (bit_ready),
    .clr_valid   (clr_valid),
    .clr_chan    (clr_chan),
`ifdef SEQ_DETECT_MATCH_CNT_EN
    .match_total (match_total),
`endif
    .match_valid (match_valid),
    .match_chan  (match_chan)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] v, input logic [3:0] d, input logic cv, input logic [1:0] cc);
    @(negedge clk);
    resetn = 1'b1; bit_valid = v; bit_data = d; clr_valid = cv; clr_chan = cc;
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    resetn = 1'b0; bit_valid = '0; bit_data = '0; clr_valid = 1'b0; clr_chan = '0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    exp_mv = 1'b0;
  endtask

  // Match pulse expected from the previous accept. Checked once, then cleared.
  task automatic chk_match(input string tag);
    chk({tag, "_mv"}, 32'(match_valid), 32'(exp_mv));
    if (exp_mv) chk({tag, "_mc"}, 32'(match_chan), 32'(exp_mc));
    exp_mv = 1'b0;
  endtask

  // Feed n bits (MSB first) on one channel alone; em flags the bits that complete 1011.
  task automatic feed(input string tag, input int ch, input logic [15:0] bits,
                      input logic [15:0] em, input int n);
    logic [3:0] v, d;
    for (int i = 0; i < n; i++) begin
      v = '0; d = '0;
      v[ch] = 1'b1;
      d[ch] = bits[n-1-i];
      cyc(v, d, 1'b0, 2'd0);
      chk({tag, "_rdy"}, 32'(bit_ready), 32'(v));
      chk_match(tag);
      exp_mv = em[n-1-i];
      exp_mc = 2'(ch);
    end
  endtask

  task automatic idle(input string tag);
    cyc(4'h0, 4'h0, 1'b0, 2'd0);
    chk({tag, "_rdy"}, 32'(bit_ready), 32'h0);
    chk_match(tag);
  endtask

  initial begin
    logic [3:0] pat;
    logic       b;
    resetn = 1'b0; bit_valid = '0; bit_data = '0; clr_valid = 1'b0; clr_chan = '0;

    // Reset state, then a single 1011 on channel 0.
    do_reset;
    chk("rst_rdy", 32'(bit_ready), 32'h0);
    chk("rst_mv",  32'(match_valid), 32'h0);
    chk("rst_mc",  32'(match_chan), 32'h0);
    feed("t1", 0, 16'b1011, 16'b0001, 4);
    idle("t1_end");
    idle("t1_quiet");

    // Overlapping matches on channel 0.
    do_reset;
    feed("t2", 0, 16'b1011011, 16'b0001001, 7);
    idle("t2_end");
    idle("t2_quiet");

    // All four channels valid, each receiving 1011 in round-robin order.
    do_reset;
    pat = 4'b1011;
    for (int j = 0; j < 16; j++) begin
      b = pat[3 - j/4];
      cyc(4'hF, {4{b}}, 1'b0, 2'd0);
      chk("t3_rdy", 32'(bit_ready), 32'(4'b0001 << (j % 4)));
      chk_match("t3");
      exp_mv = (j >= 12);
      exp_mc = 2'(j % 4);
    end
    idle("t3_end");
    idle("t3_quiet");
`ifdef SEQ_DETECT_MATCH_CNT_EN
    chk("t3_total", 32'(match_total), 32'd4);
`endif

    // A clear blocks channel 1's grant and wipes its partial match.
    do_reset;
    feed("t4a", 1, 16'b101, 16'b000, 3);
    cyc(4'b0110, 4'b0010, 1'b1, 2'd1);
    chk("t4_clr_rdy", 32'(bit_ready), 32'b0100);
    chk_match("t4_clr");
    feed("t4b", 1, 16'b1, 16'b0, 1);
    feed("t4c", 1, 16'b011, 16'b001, 3);
    idle("t4_end");
    cyc(4'b0010, 4'b0010, 1'b1, 2'd1);
    chk("t4_solo_clr_rdy", 32'(bit_ready), 32'h0);
    chk_match("t4_solo");

    // A mid-stream reset discards channel 2's S3 context and returns rr to 0.
    do_reset;
    chk("t5_rst_mc", 32'(match_chan), 32'h0);
    feed("t5a", 2, 16'b101, 16'b000, 3);
    @(negedge clk);
    resetn = 1'b0; bit_valid = '0; bit_data = '0; clr_valid = 1'b0;
    #1;
    cyc(4'hF, 4'hF, 1'b0, 2'd0);
    chk("t5_rr0_rdy", 32'(bit_ready), 32'b0001);
    chk("t5_rst_mv", 32'(match_valid), 32'h0);
    feed("t5b", 2, 16'b1011, 16'b0001, 4);
    idle("t5_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
